spi_register_controller: RTL and testbench
==========================================

SPI_REGISTER_CONTROLLER -- requirements
Module: spi_register_controller

Interface
REQ-001 Parameter NUM_REGS, default 4, number of register slots (1..16).
REQ-002 Parameter BASE_ADDR, default 8'hB0, SPI address of slot 0; slot k responds to BASE_ADDR+k.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 transaction_active  input  1  high while the SPI chip select is asserted.
REQ-006 data_in  input  8  byte received from the SPI shifter.
REQ-007 data_in_valid  input  1  one-cycle strobe; data_in is valid this cycle.
REQ-008 reg_enable  output  NUM_REGS  one-hot select of the addressed slot.
REQ-009 reg_data_in_valid  output  1  one-cycle strobe forwarding data-phase bytes to the selected slot.
REQ-010 reg_write_data  output  8  registered copy of the data-phase byte.
REQ-011 reg_byte_index  output  8  index of the current data-phase byte, starting at 0.
REQ-012 reg_data_out  input  NUM_REGS*8  read bytes; slot k occupies bits [8k+7:8k].
REQ-013 data_out  output  8  byte returned to the SPI shifter.
REQ-014 data_out_valid  output  1  one-cycle strobe; data_out is valid this cycle.
REQ-015 error_count  output  8  count of transactions that used an unknown address (see Configuration).

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ADDRESS, DATA and REJECT.
REQ-017 IDLE SHALL go to ADDRESS on the cycle after transaction_active rises.
REQ-018 In ADDRESS, the first data_in_valid SHALL latch the slot: go to DATA if data_in is in [BASE_ADDR, BASE_ADDR+NUM_REGS-1], otherwise go to REJECT.
REQ-019 The address byte SHALL NOT be forwarded on reg_data_in_valid.
REQ-020 In DATA, reg_enable SHALL be one-hot for the latched slot; it SHALL be all-zero in every other state.
REQ-021 In DATA, each data_in_valid SHALL produce, one cycle later:
  - reg_data_in_valid=1;
  - reg_write_data=data_in;
  - data_out = selected reg_data_out slice sampled at current reg_byte_index;
  - data_out_valid=1.
REQ-022 reg_byte_index SHALL be 0 on entry to DATA and SHALL increment one cycle after each data-phase strobe.
REQ-023 reg_byte_index SHALL saturate at 255 and never wrap.
REQ-024 In REJECT, each data_in_valid SHALL produce data_out=8'h00 with data_out_valid=1 one cycle later; no slot is enabled.
REQ-025 Deassertion of transaction_active in any state SHALL return the FSM to IDLE on the next edge, clearing reg_enable and reg_byte_index.
REQ-026 data_in_valid arriving in the same cycle as transaction_active falling SHALL be discarded: no strobe out, no index change.
REQ-027 data_in_valid while in IDLE SHALL be ignored.
REQ-028 A slot's reg_data_out SHALL be sampled only while that slot is selected; all other slots' inputs are don't-care.
REQ-029 data_out SHALL hold its last value between strobes.

Reset
REQ-030 Reset SHALL force all of the following, asynchronously and without waiting for a clock edge:
  - state=IDLE;
  - reg_enable=0, reg_data_in_valid=0, reg_write_data=0, reg_byte_index=0;
  - data_out=0, data_out_valid=0, error_count=0.
REQ-031 Reset asserted mid-transaction SHALL abort it; after reset release, bytes SHALL be ignored until transaction_active has been seen low and then rises again.

Configuration
REQ-032 Macro SPI_REGISTER_CONTROLLER_ERROR_COUNT_EN defined: error_count SHALL increment by 1 on each entry to REJECT and SHALL saturate at 8'hFF.
REQ-033 Macro SPI_REGISTER_CONTROLLER_ERROR_COUNT_EN undefined: error_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-034 Read slot 0 (NUM_REGS=4, BASE_ADDR=8'hB0):
  - stimulus: CS high; bytes B0,00,00,00,00; slot 0 drives "T","e","s","t" for index 0..3;
  - response: four data_out strobes 54,65,73,74; reg_enable=0001.
REQ-035 Unknown address:
  - stimulus: bytes C0,11,22;
  - response: data_out 00,00; no reg_data_in_valid; error_count goes 0->1 (macro defined) or stays 0 (macro undefined).
REQ-036 Index saturation:
  - stimulus: address B3 then 300 data bytes;
  - response: reg_byte_index reaches 255 and holds; reg_enable=1000 throughout.
REQ-037 CS fall coincident with data_in_valid:
  - response: no output strobe; IDLE next cycle; reg_enable=0.
REQ-038 Reset pulse after 2 data bytes:
  - response: all outputs 0 immediately;
  - following bytes ignored until a new CS rise; next transaction to B1 reads slot 1 from index 0.
REQ-039 Back-to-back transactions:
  - stimulus: B0 transaction, CS low one cycle, then B2 transaction;
  - response: reg_enable switches 0001 -> 0000 -> 0100; index restarts at 0.

Source files
------------

// File: rtl/spi_register_controller.sv
// spi_register_controller
// Decodes an SPI address byte into a one-hot register-slot select and then
// forwards each data-phase byte to the selected slot.  The read byte that
// slot presents for the current index goes back to the SPI shifter.
// Unknown addresses are absorbed in a REJECT state that returns zero bytes.
// Optional feature: define SPI_REGISTER_CONTROLLER_ERROR_COUNT_EN to count
// (saturating) transactions that used an unknown address; without it,
// error_count is tied to zero.
module spi_register_controller #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hB0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  transaction_active,
  input  logic [7:0]            data_in,
  input  logic                  data_in_valid,
  output logic [NUM_REGS-1:0]   reg_enable,
  output logic                  reg_data_in_valid,
  output logic [7:0]            reg_write_data,
  output logic [7:0]            reg_byte_index,
  input  logic [NUM_REGS*8-1:0] reg_data_out,
  output logic [7:0]            data_out,
  output logic                  data_out_valid,
  output logic [7:0]            error_count
);

  localparam int unsigned SLOT_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  NUM_REGS_9 = 9'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ADDRESS, DATA, REJECT} state_t;

  state_t              state;
  state_t              next_state;
  logic                cs_prev;
  logic [SLOT_W-1:0]   slot;
  logic [7:0]          offset;
  logic                addr_hit;
  logic                accept;
  logic [7:0]          sel_byte;

  // A byte is only acted on while chip select is still asserted.
  assign accept   = transaction_active && data_in_valid;
  assign offset   = data_in - BASE_ADDR;
  assign addr_hit = (data_in >= BASE_ADDR) && ({1'b0, offset} < NUM_REGS_9);

  // Chip-select history; resets high so that a select already asserted
  // when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cs_prev <= 1'b1;
    else       cs_prev <= transaction_active;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; chip-select low overrides everything.
  always_comb begin
    next_state = state;
    if (!transaction_active) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (!cs_prev) next_state = ADDRESS;
        ADDRESS: if (data_in_valid) next_state = addr_hit ? DATA : REJECT;
        default: next_state = state;
      endcase
    end
  end

  // One-hot slot select, only driven while in DATA.
  always_comb begin
    reg_enable = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_enable[k] = (state == DATA) && (slot == SLOT_W'(k));
    end
  end

  // Read-byte mux: only the latched slot's input is ever looked at.
  always_comb begin
    sel_byte = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (slot == SLOT_W'(k)) sel_byte = reg_data_out[k*8 +: 8];
    end
  end

  // Latch the addressed slot when the address byte decodes as valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (state == ADDRESS && accept && addr_hit) begin
      slot <= offset[SLOT_W-1:0];
    end
  end

  // Byte index: zero outside DATA, saturating count of data-phase strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_byte_index <= '0;
    end else if (next_state != DATA) begin
      reg_byte_index <= '0;
    end else if (state == DATA && accept && reg_byte_index != 8'hFF) begin
      reg_byte_index <= reg_byte_index + 8'd1;
    end
  end

  // Data-phase forwarding and read-byte return; data_out holds between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_data_in_valid <= 1'b0;
      reg_write_data    <= '0;
      data_out          <= '0;
      data_out_valid    <= 1'b0;
    end else begin
      reg_data_in_valid <= 1'b0;
      data_out_valid    <= 1'b0;
      if (state == DATA && accept) begin
        reg_data_in_valid <= 1'b1;
        reg_write_data    <= data_in;
        data_out          <= sel_byte;
        data_out_valid    <= 1'b1;
      end else if (state == REJECT && accept) begin
        data_out          <= '0;
        data_out_valid    <= 1'b1;
      end
    end
  end

`ifdef SPI_REGISTER_CONTROLLER_ERROR_COUNT_EN
  // Saturating count of entries into REJECT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count <= '0;
    end else if (state == ADDRESS && accept && !addr_hit && error_count != 8'hFF) begin
      error_count <= error_count + 8'd1;
    end
  end
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed testbench for spi_register_controller (NUM_REGS=4, BASE_ADDR=B0).
// Slot models: slot0 returns "Test" for index 0..3 (0 beyond),
// slot1/2/3 return 8'h10/8'h20/8'h30 plus the current byte index.
module tb_spi_register_controller;

  logic        clock;
  logic        reset;
  logic        transaction_active;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic [3:0]  reg_enable;
  logic        reg_data_in_valid;
  logic [7:0]  reg_write_data;
  logic [7:0]  reg_byte_index;
  logic [31:0] reg_data_out;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic [7:0]  error_count;
  logic [7:0]  slot0;

  int tests;
  int fails;

  spi_register_controller #(.NUM_REGS(4), .BASE_ADDR(8'hB0)) dut (
    .clock              (clock),
    .reset              (reset),
    .transaction_active (transaction_active),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .reg_enable         (reg_enable),
    .reg_data_in_valid  (reg_data_in_valid),
    .reg_write_data     (reg_write_data),
    .reg_byte_index     (reg_byte_index),
    .reg_data_out       (reg_data_out),
    .data_out           (data_out),
    .data_out_valid     (data_out_valid),
    .error_count        (error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    case (reg_byte_index)
      8'd0:    slot0 = 8'h54;
      8'd1:    slot0 = 8'h65;
      8'd2:    slot0 = 8'h73;
      8'd3:    slot0 = 8'h74;
      default: slot0 = 8'h00;
    endcase
    reg_data_out = {8'h30 + reg_byte_index, 8'h20 + reg_byte_index,
                    8'h10 + reg_byte_index, slot0};
  end

  // One-cycle byte strobe; returns on the negedge after the capturing edge.
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clock);
    data_in       = b;
    data_in_valid = 1'b1;
    @(negedge clock);
    data_in_valid = 1'b0;
  endtask

  task automatic cs_rise();
    @(negedge clock);
    transaction_active = 1'b1;
    @(negedge clock);
  endtask

  task automatic cs_fall();
    @(negedge clock);
    transaction_active = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    tests++;
    if ({reg_enable, reg_data_in_valid, reg_write_data, reg_byte_index,
         data_out, data_out_valid, error_count} !== '0) begin
      fails++;
      $display("FAIL reset_state: enable=%b rdiv=%b wd=%h idx=%h dout=%h dov=%b err=%h, required all 0",
               reg_enable, reg_data_in_valid, reg_write_data, reg_byte_index,
               data_out, data_out_valid, error_count);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_byte(8'hB0);
    tests++;
    if (data_out_valid !== 1'b0 || reg_enable !== 4'b0000) begin
      fails++;
      $display("FAIL idle_ignore: dov=%b enable=%b, required 0 and 0000", data_out_valid, reg_enable);
    end
  endtask

  task automatic test_read_slot0();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h54, 8'h65, 8'h73, 8'h74};
    cs_rise();
    drive_byte(8'hB0);
    tests++;
    if (reg_enable !== 4'b0001 || reg_data_in_valid !== 1'b0 || data_out_valid !== 1'b0
        || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL read_addr: enable=%b rdiv=%b dov=%b idx=%0d, required 0001 0 0 0",
               reg_enable, reg_data_in_valid, data_out_valid, reg_byte_index);
    end
    for (int i = 0; i < 4; i++) begin
      drive_byte(8'h00);
      tests++;
      if (data_out_valid !== 1'b1 || data_out !== exp_bytes[i] || reg_data_in_valid !== 1'b1
          || reg_write_data !== 8'h00 || reg_byte_index !== 8'(i + 1) || reg_enable !== 4'b0001) begin
        fails++;
        $display("FAIL read_byte%0d: dov=%b dout=%h rdiv=%b wd=%h idx=%0d en=%b, required 1 %h 1 00 %0d 0001",
                 i, data_out_valid, data_out, reg_data_in_valid, reg_write_data,
                 reg_byte_index, reg_enable, exp_bytes[i], i + 1);
      end
    end
    @(negedge clock);
    tests++;
    if (data_out_valid !== 1'b0 || data_out !== 8'h74) begin
      fails++;
      $display("FAIL dout_hold: dov=%b dout=%h, required 0 74", data_out_valid, data_out);
    end
    cs_fall();
    tests++;
    if (reg_enable !== 4'b0000 || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL read_end: enable=%b idx=%0d, required 0000 0", reg_enable, reg_byte_index);
    end
  endtask

  task automatic test_unknown_addr();
    logic [7:0] exp_err;
`ifdef SPI_REGISTER_CONTROLLER_ERROR_COUNT_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    cs_rise();
    drive_byte(8'hC0);
    drive_byte(8'h11);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h00 || reg_data_in_valid !== 1'b0
        || reg_enable !== 4'b0000) begin
      fails++;
      $display("FAIL reject_b1: dov=%b dout=%h rdiv=%b en=%b, required 1 00 0 0000",
               data_out_valid, data_out, reg_data_in_valid, reg_enable);
    end
    drive_byte(8'h22);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h00 || reg_data_in_valid !== 1'b0
        || reg_write_data !== 8'h00) begin
      fails++;
      $display("FAIL reject_b2: dov=%b dout=%h rdiv=%b wd=%h, required 1 00 0 00",
               data_out_valid, data_out, reg_data_in_valid, reg_write_data);
    end
    tests++;
    if (error_count !== exp_err) begin
      fails++;
      $display("FAIL error_count: got %0d, required %0d", error_count, exp_err);
    end
    cs_fall();
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    cs_rise();
    drive_byte(8'hB3);
    for (int i = 0; i < 300; i++) begin
      drive_byte(8'(i));
      if (reg_enable !== 4'b1000) bad++;
      if (i == 254) begin
        tests++;
        if (reg_byte_index !== 8'd255) begin
          fails++;
          $display("FAIL sat_reach: idx=%0d, required 255", reg_byte_index);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sat_enable: %0d cycles with enable!=1000, required 0", bad);
    end
    tests++;
    if (reg_byte_index !== 8'd255 || data_out !== 8'h2F || reg_write_data !== 8'h2B) begin
      fails++;
      $display("FAIL sat_hold: idx=%0d dout=%h wd=%h, required 255 2f 2b",
               reg_byte_index, data_out, reg_write_data);
    end
    cs_fall();
  endtask

  task automatic test_cs_fall_coincident();
    cs_rise();
    drive_byte(8'hB1);
    drive_byte(8'h77);
    tests++;
    if (data_out !== 8'h10 || reg_byte_index !== 8'd1) begin
      fails++;
      $display("FAIL csfall_pre: dout=%h idx=%0d, required 10 1", data_out, reg_byte_index);
    end
    @(negedge clock);
    transaction_active = 1'b0;
    data_in            = 8'h55;
    data_in_valid      = 1'b1;
    @(negedge clock);
    data_in_valid = 1'b0;
    tests++;
    if (data_out_valid !== 1'b0 || reg_data_in_valid !== 1'b0 || reg_enable !== 4'b0000
        || reg_write_data !== 8'h77 || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL csfall_discard: dov=%b rdiv=%b en=%b wd=%h idx=%0d, required 0 0 0000 77 0",
               data_out_valid, reg_data_in_valid, reg_enable, reg_write_data, reg_byte_index);
    end
  endtask

  task automatic test_reset_mid();
    cs_rise();
    drive_byte(8'hB0);
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({reg_enable, reg_data_in_valid, reg_write_data, reg_byte_index,
         data_out, data_out_valid, error_count} !== '0) begin
      fails++;
      $display("FAIL reset_async: en=%b rdiv=%b wd=%h idx=%h dout=%h dov=%b err=%h, required all 0",
               reg_enable, reg_data_in_valid, reg_write_data, reg_byte_index,
               data_out, data_out_valid, error_count);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_byte(8'hB1);
    drive_byte(8'h99);
    tests++;
    if (data_out_valid !== 1'b0 || reg_data_in_valid !== 1'b0 || reg_enable !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ignore: dov=%b rdiv=%b en=%b, required 0 0 0000",
               data_out_valid, reg_data_in_valid, reg_enable);
    end
    cs_fall();
    cs_rise();
    drive_byte(8'hB1);
    tests++;
    if (reg_enable !== 4'b0010 || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL reset_next_addr: en=%b idx=%0d, required 0010 0", reg_enable, reg_byte_index);
    end
    drive_byte(8'h01);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h10 || reg_byte_index !== 8'd1) begin
      fails++;
      $display("FAIL reset_next_read: dov=%b dout=%h idx=%0d, required 1 10 1",
               data_out_valid, data_out, reg_byte_index);
    end
    cs_fall();
  endtask

  task automatic test_back_to_back();
    cs_rise();
    drive_byte(8'hB0);
    drive_byte(8'h00);
    tests++;
    if (reg_enable !== 4'b0001 || data_out !== 8'h54 || reg_byte_index !== 8'd1) begin
      fails++;
      $display("FAIL b2b_first: en=%b dout=%h idx=%0d, required 0001 54 1",
               reg_enable, data_out, reg_byte_index);
    end
    @(negedge clock);
    transaction_active = 1'b0;
    @(negedge clock);
    tests++;
    if (reg_enable !== 4'b0000 || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL b2b_gap: en=%b idx=%0d, required 0000 0", reg_enable, reg_byte_index);
    end
    transaction_active = 1'b1;
    @(negedge clock);
    drive_byte(8'hB2);
    tests++;
    if (reg_enable !== 4'b0100 || reg_byte_index !== 8'd0) begin
      fails++;
      $display("FAIL b2b_second: en=%b idx=%0d, required 0100 0", reg_enable, reg_byte_index);
    end
    drive_byte(8'h5A);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h20 || reg_write_data !== 8'h5A
        || reg_byte_index !== 8'd1) begin
      fails++;
      $display("FAIL b2b_read: dov=%b dout=%h wd=%h idx=%0d, required 1 20 5a 1",
               data_out_valid, data_out, reg_write_data, reg_byte_index);
    end
    cs_fall();
  endtask

  initial begin
    tests              = 0;
    fails              = 0;
    reset              = 1'b1;
    transaction_active = 1'b0;
    data_in            = 8'h00;
    data_in_valid      = 1'b0;
    #12;
    test_reset();
    test_read_slot0();
    test_unknown_addr();
    test_saturation();
    test_cs_fall_coincident();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
